inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-low (asserted = 0).
REQ-004 SHALL have port stall, input, 1: decode hazard; holds the PC and the IF/ID latch.
REQ-005 SHALL have port jmpEn, input, 1: redirect request from branch/jump resolution.
REQ-006 SHALL have port jmpAddr, input, 32: redirect target byte address.
REQ-007 SHALL have port romCe, output, 1: chip enable to the instruction ROM, using RomEnable/RomDisable encoding.
REQ-008 SHALL have port romAddr, output, 32: current PC presented to the ROM.
REQ-009 SHALL have port romData, input, 32: combinational ROM read data for romAddr.
REQ-010 SHALL have port idPc, output, 32: PC of the instruction latched for decode.
REQ-011 SHALL have port idInst, output, 32: instruction latched for decode.
REQ-012 SHALL have port idValid, output, 1: idInst is a real fetched instruction.
REQ-013 SHALL have port fetchCnt, output, 16: count of instructions accepted into IF/ID.

Function
REQ-014 SHALL drive romCe to RomDisable from reset assertion until the first rising edge after reset release, and to RomEnable on every cycle after that.
REQ-015 SHALL drive romAddr directly from the PC register, with no combinational path from any input.
REQ-016 SHALL hold the PC while romCe = RomDisable.
REQ-017 SHALL load the PC, on an edge with romCe enabled and jmpEn = 1, with {jmpAddr[31:2], 2'b00}; misaligned low bits are silently cleared.
REQ-018 SHALL hold the PC, on an edge with romCe enabled, jmpEn = 0 and stall = 1.
REQ-019 SHALL otherwise advance the PC by 4 on each edge, modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-020 SHALL give jmpEn priority over stall when both are asserted in the same cycle.
REQ-021 SHALL, on an edge with jmpEn = 1, flush the IF/ID latch: idInst = 32'h0 (nop), idValid = 0, idPc unchanged.
REQ-022 SHALL, on an edge with jmpEn = 0 and stall = 1, hold idPc, idInst, idValid and fetchCnt.
REQ-023 SHALL, on an edge with jmpEn = 0, stall = 0 and romCe enabled, latch idPc = PC, idInst = romData, idValid = 1.
REQ-024 SHALL, on an edge with romCe disabled, set idValid = 0 and idInst = 0.
REQ-025 SHALL increment fetchCnt by 1 on each REQ-023 latch, wrapping 16'hFFFF to 0.
REQ-026 SHALL present fetch-to-decode latency as exactly one cycle: the instruction at PC p appears on idInst one edge after romAddr = p.

Reset
REQ-027 SHALL, while rst = 0, asynchronously force PC = RESET_PC, romCe = RomDisable, idPc = 0, idInst = 0, idValid = 0, fetchCnt = 0.
REQ-028 SHALL apply REQ-027 fully on reset assertion mid-stall or mid-redirect, discarding any pending jmpEn.

Structure
REQ-029 SHALL take RomEnable, RomDisable, Zero and a new Nop word constant (32'h0) from the shared define file, with no local literals for these.
REQ-030 SHALL place the PC register and its next-PC priority mux (jump > stall > +4) in one sub-module, pc_reg; the IF/ID latch and counter SHALL stay in inst_fetch.

Verification
REQ-031 SHALL check reset: hold rst = 0 for 3 cycles -> romCe = RomDisable, romAddr = 0, idValid = 0, fetchCnt = 0; first edge after release -> romCe = RomEnable, romAddr = 0.
REQ-032 SHALL check straight-line fetch with the ROM preloaded (word0 = 32'h34011100, word1 = 32'h30020020) -> successive edges give idInst = 34011100 with idPc = 0, then 30020020 with idPc = 4; romAddr = 8; fetchCnt = 2.
REQ-033 SHALL check stall: stall = 1 for 2 cycles at romAddr = 8 -> romAddr, idInst, idPc and fetchCnt frozen; release -> fetch resumes at 8 with no lost or duplicated word.
REQ-034 SHALL check redirect: jmpEn = 1, jmpAddr = 32'h23 together with stall = 1 -> next romAddr = 32'h20, idValid = 0, idInst = 0; following edge -> idPc = 32'h20, idValid = 1.
REQ-035 SHALL check wrap: force PC to 32'hFFFF_FFFC -> next romAddr = 0; preload fetchCnt to 16'hFFFF and accept one fetch -> fetchCnt = 0.
REQ-036 SHALL check mid-operation reset: assert rst between edges during a jmpEn pulse -> all outputs take REQ-027 values immediately, with no clock edge needed.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared ROM-enable encodings and word constants for the fetch stage
package inst_fetch_pkg;
   localparam logic        RomEnable  = 1'b1;
   localparam logic        RomDisable = 1'b0;
   localparam logic [31:0] Zero       = 32'h0000_0000;
   localparam logic [31:0] Nop        = 32'h0000_0000;
   function automatic logic [31:0] word_align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction
endpackage

// File: rtl/inst_fetch_pc_reg.sv
// pc_reg: program counter with jump > stall > +4 next-PC selection, frozen while the ROM is disabled
module pc_reg
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        stall,
   input  logic        jmp_en,
   input  logic [31:0] jmp_addr,
   output logic [31:0] pc
);
   logic [31:0] pc_next;
   always_comb
      pc_next = (ce == RomDisable) ? pc :
                jmp_en             ? word_align(jmp_addr) :
                stall              ? pc : pc + 32'd4;
   always_ff @(posedge clk or negedge rst)
      if (!rst) pc <= RESET_PC;
      else      pc <= pc_next;
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: PC sequencing, instruction ROM interface and the IF/ID pipeline latch
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        jmpEn,
   input  logic [31:0] jmpAddr,
   output logic        romCe,
   output logic [31:0] romAddr,
   input  logic [31:0] romData,
   output logic [31:0] idPc,
   output logic [31:0] idInst,
   output logic        idValid,
   output logic [15:0] fetchCnt
);
   pc_reg #(.RESET_PC(RESET_PC)) u_pc (
      .clk     (clk),
      .rst     (rst),
      .ce      (romCe),
      .stall   (stall),
      .jmp_en  (jmpEn),
      .jmp_addr(jmpAddr),
      .pc      (romAddr)
   );
   // A disabled ROM or a redirect both leave a bubble in decode
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         romCe    <= RomDisable;
         idPc     <= Zero;
         idInst   <= Nop;
         idValid  <= 1'b0;
         fetchCnt <= 16'h0;
      end else begin
         romCe <= RomEnable;
         if (romCe == RomDisable || jmpEn) begin
            idInst  <= Nop;
            idValid <= 1'b0;
         end else if (!stall) begin
            idPc     <= romAddr;
            idInst   <= romData;
            idValid  <= 1'b1;
            fetchCnt <= fetchCnt + 16'd1;
         end
      end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed and randomized checks of inst_fetch against a behavioural model
module tb_inst_fetch;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        jmpEn = 1'b0;
   logic [31:0] jmpAddr = 32'h0;
   logic        romCe;
   logic [31:0] romAddr;
   logic [31:0] romData;
   logic [31:0] idPc;
   logic [31:0] idInst;
   logic        idValid;
   logic [15:0] fetchCnt;

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   logic        m_ce;
   logic [31:0] m_pc, m_id_pc, m_id_inst;
   logic        m_id_valid;
   int          m_cnt;

   inst_fetch #(.RESET_PC(32'h0)) dut (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .jmpEn   (jmpEn),
      .jmpAddr (jmpAddr),
      .romCe   (romCe),
      .romAddr (romAddr),
      .romData (romData),
      .idPc    (idPc),
      .idInst  (idInst),
      .idValid (idValid),
      .fetchCnt(fetchCnt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h3401_1100;
      if (a == 32'h4) return 32'h3002_0020;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign romData = rom_word(romAddr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         if (n_err <= 30) $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_ce = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0; m_cnt = 0;
   endtask

   task automatic m_edge();
      if (!m_ce) begin
         m_id_inst = 32'h0; m_id_valid = 1'b0; m_ce = 1'b1;
      end else if (jmpEn) begin
         m_pc = jmpAddr & ~32'h3; m_id_inst = 32'h0; m_id_valid = 1'b0;
      end else if (!stall) begin
         m_id_pc = m_pc; m_id_inst = rom_word(m_pc); m_id_valid = 1'b1;
         m_cnt = (m_cnt + 1) % 65536; m_pc = m_pc + 32'd4;
      end
   endtask

   task automatic chk_model();
      chk("romCe", 32'(romCe), 32'(m_ce));
      chk("romAddr", romAddr, m_pc);
      chk("idPc", idPc, m_id_pc);
      chk("idInst", idInst, m_id_inst);
      chk("idValid", 32'(idValid), 32'(m_id_valid));
      chk("fetchCnt", 32'(fetchCnt), 32'(m_cnt));
   endtask

   // drive inputs at negedge, clock once, check at the next negedge
   task automatic step(input logic s, input logic j, input logic [31:0] a);
      stall = s; jmpEn = j; jmpAddr = a;
      @(posedge clk);
      m_edge();
      @(negedge clk);
      chk_model();
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".romCe"}, 32'(romCe), 32'h0);
      chk({tag, ".romAddr"}, romAddr, 32'h0);
      chk({tag, ".idPc"}, idPc, 32'h0);
      chk({tag, ".idInst"}, idInst, 32'h0);
      chk({tag, ".idValid"}, 32'(idValid), 32'h0);
      chk({tag, ".fetchCnt"}, 32'(fetchCnt), 32'h0);
   endtask

   initial begin
      m_reset();
      repeat (3) @(negedge clk);
      chk_reset_vals("rst_hold");
      rst = 1'b1;
      step(1'b0, 1'b0, 32'h0);
      chk("first_ce", 32'(romCe), 32'h1);
      chk("first_addr", romAddr, 32'h0);
      // straight-line fetch
      step(1'b0, 1'b0, 32'h0);
      chk("w0_inst", idInst, 32'h3401_1100);
      chk("w0_pc", idPc, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("w1_inst", idInst, 32'h3002_0020);
      chk("w1_pc", idPc, 32'h4);
      chk("w1_addr", romAddr, 32'h8);
      chk("w1_cnt", 32'(fetchCnt), 32'h2);
      // stall holds everything
      step(1'b1, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0);
      chk("stall_addr", romAddr, 32'h8);
      chk("stall_inst", idInst, 32'h3002_0020);
      chk("stall_pc", idPc, 32'h4);
      chk("stall_cnt", 32'(fetchCnt), 32'h2);
      step(1'b0, 1'b0, 32'h0);
      chk("resume_pc", idPc, 32'h8);
      chk("resume_inst", idInst, rom_word(32'h8));
      chk("resume_cnt", 32'(fetchCnt), 32'h3);
      // jump beats stall, misaligned target cleared
      step(1'b1, 1'b1, 32'h23);
      chk("jmp_addr", romAddr, 32'h20);
      chk("jmp_valid", 32'(idValid), 32'h0);
      chk("jmp_inst", idInst, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("jmp_idpc", idPc, 32'h20);
      chk("jmp_valid2", 32'(idValid), 32'h1);
      // PC wrap
      step(1'b0, 1'b1, 32'hFFFF_FFFF);
      chk("wrap_pre", romAddr, 32'hFFFF_FFFC);
      step(1'b0, 1'b0, 32'h0);
      chk("wrap_addr", romAddr, 32'h0);
      chk("wrap_idpc", idPc, 32'hFFFF_FFFC);
      // randomized traffic
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom);
      // drive the counter to its top value, then wrap it
      for (int i = 0; i < 70000 && m_cnt != 65535; i++)
         step(1'b0, 1'b0, 32'h0);
      chk("cnt_top", 32'(fetchCnt), 32'hFFFF);
      step(1'b0, 1'b0, 32'h0);
      chk("cnt_wrap", 32'(fetchCnt), 32'h0);
      // asynchronous reset between edges during a redirect
      stall = 1'b1; jmpEn = 1'b1; jmpAddr = 32'h0000_1234;
      #2 rst = 1'b0;
      #1 chk_reset_vals("async_rst");
      m_reset();
      @(negedge clk);
      chk_reset_vals("async_hold");
      stall = 1'b0; jmpEn = 1'b0;
      rst = 1'b1;
      step(1'b0, 1'b0, 32'h0);
      step(1'b0, 1'b0, 32'h0);
      chk("post_rst_inst", idInst, 32'h3401_1100);
      for (int i = 0; i < 200; i++)
         step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
